// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath: ALU opcodes, write-back select encodings and the
// PSR flag bit positions.
package datapath_pkg;

  localparam logic [5:0] AluAnd  = 6'b000001;
  localparam logic [5:0] AluOr   = 6'b000010;
  localparam logic [5:0] AluXor  = 6'b000011;
  localparam logic [5:0] AluLsh  = 6'b000100;
  localparam logic [5:0] AluAdd  = 6'b000101;
  localparam logic [5:0] AluSub  = 6'b001001;
  localparam logic [5:0] AluCmp  = 6'b001011;
  localparam logic [5:0] AluPass = 6'b111111;

  typedef enum logic [1:0] {
    WbAlu   = 2'd0,
    WbMem   = 2'd1,
    WbImmHi = 2'd2,
    WbZero  = 2'd3
  } wb_src_e;

  localparam int unsigned NumFlags = 5;
  localparam int unsigned FlagN    = 0;
  localparam int unsigned FlagZ    = 1;
  localparam int unsigned FlagF    = 2;
  localparam int unsigned FlagL    = 3;
  localparam int unsigned FlagC    = 4;

  // Only the arithmetic compare-class ops are allowed to touch the PSR.
  function automatic logic flags_update(input logic [5:0] op);
    return (op == AluAdd) || (op == AluSub) || (op == AluCmp);
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational 16-bit ALU. Produces the result and the full candidate flag vector;
// the caller decides whether the flags are latched.
module alu
  import datapath_pkg::*;
(
  input  logic [15:0]         a_i,
  input  logic [15:0]         b_i,
  input  logic [5:0]          alu_cont_i,
  output logic [15:0]         result_o,
  output logic [NumFlags-1:0] flags_o
);

  logic [16:0] sum;
  logic [16:0] diff;
  logic [15:0] neg_b;
  logic        carry;
  logic        ovf;
  logic        zero;

  always_comb begin
    sum   = {1'b0, a_i} + {1'b0, b_i};
    // Bit 16 of the widened difference is set exactly when a borrow occurs (a < b).
    diff  = {1'b0, a_i} - {1'b0, b_i};
    neg_b = 16'd0 - b_i;
    carry = 1'b0;
    ovf   = 1'b0;

    case (alu_cont_i)
      AluAdd: begin
        result_o = sum[15:0];
        carry    = sum[16];
        ovf      = (a_i[15] == b_i[15]) && (sum[15] != a_i[15]);
      end
      AluSub, AluCmp: begin
        result_o = (alu_cont_i == AluSub) ? diff[15:0] : a_i;
        carry    = diff[16];
        ovf      = (a_i[15] != b_i[15]) && (diff[15] != a_i[15]);
      end
      AluAnd:  result_o = a_i & b_i;
      AluOr:   result_o = a_i | b_i;
      AluXor:  result_o = a_i ^ b_i;
      // Negative shift amounts (B[4] set) shift right by the magnitude.
      AluLsh:  result_o = b_i[4] ? (a_i >> neg_b[3:0]) : (a_i << b_i[3:0]);
      AluPass: result_o = b_i;
      default: result_o = a_i;
    endcase

    zero = (alu_cont_i == AluCmp) ? (a_i == b_i) : (result_o == 16'd0);

    flags_o        = '0;
    flags_o[FlagC] = carry;
    flags_o[FlagL] = a_i < b_i;
    flags_o[FlagF] = ovf;
    flags_o[FlagZ] = zero;
    flags_o[FlagN] = $signed(a_i) < $signed(b_i);
  end

endmodule

// File: rtl/datapath.sv
// Single-cycle datapath: 16x16 register file, operand and write-back muxes, ALU and
// the PSR flag register.
module datapath
  import datapath_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_write,
  input  logic        alu_A_src,
  input  logic        alu_B_src,
  input  logic [1:0]  reg_write_src,
  input  logic [5:0]  alu_cont,
  input  logic [15:0] data_from_mem_PC,
  input  logic [15:0] data_from_mem_load,
  output logic [15:0] mem_address_load_stor,
  output logic [15:0] data_to_mem_stor,
  output logic [3:0]  op_code,
  output logic [3:0]  A_index,
  output logic [3:0]  ext_op_code,
  output logic [3:0]  B_index,
  output logic [4:0]  psr_flags
);

  logic [15:0]         regs_q [16];
  logic [15:0]         regs_d [16];
  logic [NumFlags-1:0] flags_q;
  logic [NumFlags-1:0] flags_d;

  logic [7:0]          imm8;
  logic [15:0]         imm_sext;
  logic [15:0]         alu_a;
  logic [15:0]         alu_b;
  logic [15:0]         alu_result;
  logic [NumFlags-1:0] alu_flags;
  logic [15:0]         wb_data;
  wb_src_e             wb_sel;

  assign op_code     = data_from_mem_PC[15:12];
  assign A_index     = data_from_mem_PC[11:8];
  assign ext_op_code = data_from_mem_PC[7:4];
  assign B_index     = data_from_mem_PC[3:0];
  assign imm8        = data_from_mem_PC[7:0];
  assign imm_sext    = {{8{imm8[7]}}, imm8};

  assign alu_a = alu_A_src ? regs_q[A_index] : 16'h0000;
  assign alu_b = alu_B_src ? imm_sext : regs_q[B_index];

  assign mem_address_load_stor = alu_b;
  assign data_to_mem_stor      = regs_q[A_index];
  assign psr_flags             = flags_q;

  alu u_alu (
    .a_i        (alu_a),
    .b_i        (alu_b),
    .alu_cont_i (alu_cont),
    .result_o   (alu_result),
    .flags_o    (alu_flags)
  );

  assign wb_sel = wb_src_e'(reg_write_src);

  always_comb begin
    case (wb_sel)
      WbAlu:   wb_data = alu_result;
      WbMem:   wb_data = data_from_mem_load;
      WbImmHi: wb_data = {imm8, 8'h00};
      default: wb_data = 16'h0000;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (reg_write) begin
      regs_d[A_index] = wb_data;
    end
    flags_d = flags_q;
    if (flags_update(alu_cont)) begin
      flags_d = alu_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= 16'h0000;
      end
      flags_q <= '0;
    end else begin
      regs_q  <= regs_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for the datapath: stimulus pushes expected output values, a negedge
// monitor pops and compares them against the live DUT outputs.
module tb_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write;
  logic        alu_A_src;
  logic        alu_B_src;
  logic [1:0]  reg_write_src;
  logic [5:0]  alu_cont;
  logic [15:0] data_from_mem_PC;
  logic [15:0] data_from_mem_load;
  logic [15:0] mem_address_load_stor;
  logic [15:0] data_to_mem_stor;
  logic [3:0]  op_code;
  logic [3:0]  A_index;
  logic [3:0]  ext_op_code;
  logic [3:0]  B_index;
  logic [4:0]  psr_flags;

  localparam logic [5:0] OpAdd  = 6'b000101;
  localparam logic [5:0] OpCmp  = 6'b001011;
  localparam logic [5:0] OpSub  = 6'b001001;
  localparam logic [5:0] OpLsh  = 6'b000100;
  localparam logic [5:0] OpPass = 6'b111111;
  localparam logic [5:0] OpNone = 6'b000000;

  localparam int SelAddr  = 0;
  localparam int SelWdata = 1;
  localparam int SelFlags = 2;
  localparam int SelOp    = 3;
  localparam int SelAIdx  = 4;
  localparam int SelExt   = 5;
  localparam int SelBIdx  = 6;

  string       name_q[$];
  int          sel_q[$];
  logic [15:0] val_q[$];

  int checks = 0;
  int errors = 0;

  logic        mem_we;
  logic [15:0] mem [256];

  always #5 clk = ~clk;

  datapath dut (
    .clk                   (clk),
    .reset                 (reset),
    .reg_write             (reg_write),
    .alu_A_src             (alu_A_src),
    .alu_B_src             (alu_B_src),
    .reg_write_src         (reg_write_src),
    .alu_cont              (alu_cont),
    .data_from_mem_PC      (data_from_mem_PC),
    .data_from_mem_load    (data_from_mem_load),
    .mem_address_load_stor (mem_address_load_stor),
    .data_to_mem_stor      (data_to_mem_stor),
    .op_code               (op_code),
    .A_index               (A_index),
    .ext_op_code           (ext_op_code),
    .B_index               (B_index),
    .psr_flags             (psr_flags)
  );

  // Synchronous memory: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_we) mem[mem_address_load_stor[7:0]] <= data_to_mem_stor;
    data_from_mem_load <= mem[mem_address_load_stor[7:0]];
  end

  function automatic logic [15:0] pick(input int sel);
    case (sel)
      SelAddr:  return mem_address_load_stor;
      SelWdata: return data_to_mem_stor;
      SelFlags: return {11'd0, psr_flags};
      SelOp:    return {12'd0, op_code};
      SelAIdx:  return {12'd0, A_index};
      SelExt:   return {12'd0, ext_op_code};
      default:  return {12'd0, B_index};
    endcase
  endfunction

  always @(negedge clk) begin
    while (sel_q.size() > 0) begin
      string       n;
      int          s;
      logic [15:0] v;
      logic [15:0] act;
      n   = name_q.pop_front();
      s   = sel_q.pop_front();
      v   = val_q.pop_front();
      act = pick(s);
      checks++;
      if (act !== v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", n, act, v);
      end
    end
  end

  task automatic expect_out(input string n, input int sel, input logic [15:0] v);
    name_q.push_back(n);
    sel_q.push_back(sel);
    val_q.push_back(v);
  endtask

  task automatic drive(input logic [15:0] inst, input logic we, input logic a_src,
                       input logic b_src, input logic [1:0] wsrc, input logic [5:0] cont);
    data_from_mem_PC = inst;
    reg_write        = we;
    alu_A_src        = a_src;
    alu_B_src        = b_src;
    reg_write_src    = wsrc;
    alu_cont         = cont;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read R[idx] through the store-data port without disturbing state.
  task automatic read_reg(input string n, input logic [3:0] idx, input logic [15:0] v);
    drive({4'h0, idx, 8'h00}, 1'b0, 1'b0, 1'b1, 2'd0, OpNone);
    expect_out(n, SelWdata, v);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem_we = 1'b0;
    reset  = 1'b0;
    drive(16'h0000, 1'b1, 1'b0, 1'b0, 2'd0, OpNone);
    tick();
    tick();
    reset = 1'b1;

    drive(16'h0100, 1'b0, 1'b0, 1'b0, 2'd0, OpNone);
    expect_out("reset_flags", SelFlags, 16'h0000);
    expect_out("reset_r1", SelWdata, 16'h0000);
    tick();

    // Load immediates R1=3, R2=2
    drive(16'h0103, 1'b1, 1'b0, 1'b1, 2'd0, OpPass);
    expect_out("li_addr", SelAddr, 16'h0003);
    tick();
    drive(16'h0202, 1'b1, 1'b0, 1'b1, 2'd0, OpPass);
    tick();

    // ADD R1 = R1 + R2; same-cycle reads see old values
    drive(16'h0102, 1'b1, 1'b1, 1'b0, 2'd0, OpAdd);
    expect_out("add_rb", SelAddr, 16'h0002);
    expect_out("add_ra", SelWdata, 16'h0003);
    tick();
    expect_out("add_flags", SelFlags, 16'h0000);

    // Store R1 to address 4
    drive(16'h0104, 1'b0, 1'b1, 1'b1, 2'd0, OpNone);
    mem_we = 1'b1;
    expect_out("st_addr", SelAddr, 16'h0004);
    expect_out("st_data", SelWdata, 16'h0005);
    expect_out("st_ext", SelExt, 16'h0000);
    expect_out("st_bidx", SelBIdx, 16'h0004);
    tick();
    mem_we = 1'b0;

    // Load from address 4 into R3
    tick();
    drive(16'h0300, 1'b1, 1'b0, 1'b0, 2'd1, OpNone);
    expect_out("ld_aidx", SelAIdx, 16'h0003);
    expect_out("ld_op", SelOp, 16'h0000);
    tick();
    read_reg("ld_r3", 4'd3, 16'h0005);

    // ADD 0xFFFF + 1
    drive(16'h04FF, 1'b1, 1'b0, 1'b1, 2'd0, OpPass);
    expect_out("li_ffff", SelAddr, 16'hFFFF);
    tick();
    drive(16'h0401, 1'b1, 1'b1, 1'b1, 2'd0, OpAdd);
    tick();
    expect_out("wrap_flags", SelFlags, 16'h0013);
    read_reg("wrap_r4", 4'd4, 16'h0000);

    // imm8 0x80 sign extends
    drive(16'h0580, 1'b1, 1'b0, 1'b1, 2'd0, OpPass);
    expect_out("sext_addr", SelAddr, 16'hFF80);
    tick();
    read_reg("sext_r5", 4'd5, 16'hFF80);

    // R6 = {imm8, 00} = 0x8000; CMP R6 vs 1
    drive(16'h0680, 1'b1, 1'b0, 1'b1, 2'd2, OpNone);
    tick();
    read_reg("immhi_r6", 4'd6, 16'h8000);
    drive(16'h0601, 1'b0, 1'b1, 1'b1, 2'd0, OpCmp);
    tick();
    expect_out("cmp_flags", SelFlags, 16'h0005);
    read_reg("cmp_r6", 4'd6, 16'h8000);

    // Shifts: R7=1, <<4 -> 0x10, >>2 -> 0x4; flags must hold
    drive(16'h0701, 1'b1, 1'b0, 1'b1, 2'd0, OpPass);
    tick();
    drive(16'h0704, 1'b1, 1'b1, 1'b1, 2'd0, OpLsh);
    tick();
    read_reg("lsh_left", 4'd7, 16'h0010);
    drive(16'h07FE, 1'b1, 1'b1, 1'b1, 2'd0, OpLsh);
    tick();
    read_reg("lsh_right", 4'd7, 16'h0004);
    expect_out("flags_hold", SelFlags, 16'h0005);
    tick();

    // SUB R7 = 4 - 5 (via imm), borrow and negative
    drive(16'h0705, 1'b1, 1'b1, 1'b1, 2'd0, OpSub);
    tick();
    expect_out("sub_flags", SelFlags, 16'h0019);
    read_reg("sub_r7", 4'd7, 16'hFFFF);

    // Reset overrides a pending write
    reset = 1'b0;
    drive(16'h0109, 1'b1, 1'b0, 1'b1, 2'd0, OpPass);
    tick();
    reset = 1'b1;
    drive(16'h0100, 1'b0, 1'b0, 1'b0, 2'd0, OpNone);
    expect_out("rst2_flags", SelFlags, 16'h0000);
    expect_out("rst2_r1", SelWdata, 16'h0000);
    tick();
    read_reg("rst2_r7", 4'd7, 16'h0000);
    read_reg("rst2_r3", 4'd3, 16'h0000);

    for (int i = 0; i < 10 && sel_q.size() > 0; i++) tick();
    if (sel_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sel_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL: clk, input, 1, single clock; all state updates on the rising edge.
REQ-002 SHALL: reset, input, 1, synchronous, active-low; sampled only on the rising clk edge.
REQ-003 SHALL: reg_write, input, 1, register-file write enable.
REQ-004 SHALL: alu_A_src, input, 1, ALU A select (0 = 16'h0000, 1 = R[A_index]).
REQ-005 SHALL: alu_B_src, input, 1, ALU B select (0 = R[B_index], 1 = sign-extended imm8).
REQ-006 SHALL: reg_write_src, input, 2, write-back select (0 = ALU result, 1 = data_from_mem_load, 2 = {imm8, 8'h00}, 3 = 16'h0000).
REQ-007 SHALL: alu_cont, input, 6, ALU operation code.
REQ-008 SHALL: data_from_mem_PC, input, 16, current instruction word.
REQ-009 SHALL: data_from_mem_load, input, 16, memory read data.
REQ-010 SHALL: mem_address_load_stor, output, 16, memory address.
REQ-011 SHALL: data_to_mem_stor, output, 16, memory write data.
REQ-012 SHALL: op_code / A_index / ext_op_code / B_index, outputs, 4 each, instruction bits [15:12] / [11:8] / [7:4] / [3:0].
REQ-013 SHALL: psr_flags, output, 5, registered flags {C, L, F, Z, N}.

Function
REQ-014 SHALL: imm8 = instruction[7:0]; the ALU B immediate is imm8 sign-extended to 16 bits.
REQ-015 SHALL: register file 16 x 16 bits, two combinational read ports (A_index, B_index), one write port addressed by A_index.
REQ-016 SHALL: while reg_write=1 and reset=1, R[A_index] takes the write-back mux value at the rising edge; reads in the same cycle return the old value.
REQ-017 SHALL: ALU is purely combinational; zero-cycle latency from inputs to result.
REQ-018 SHALL: alu_cont encodings: 000101 ADD, 001001 SUB (A-B), 001011 CMP (result = A), 000001 AND, 000010 OR, 000011 XOR, 000100 LSH (shift A left by B[3:0] when B[4]=0, else logical right by (-B)[3:0]), 111111 PASS (result = B); any other code yields result = A.
REQ-019 SHALL: all arithmetic wraps modulo 2^16.
REQ-020 SHALL: mem_address_load_stor = ALU B operand (the alu_B_src mux output); data_to_mem_stor = R[A_index]; both combinational.
REQ-021 SHALL: memory read data is consumed one cycle after the address is presented; data_from_mem_load is written back when reg_write_src=1 and reg_write=1.
REQ-022 SHALL: flags update on a rising edge when alu_cont is ADD, SUB or CMP. C = unsigned carry/borrow; F = signed overflow; Z = (A == B) for CMP, result==0 otherwise; N = signed A < B; L = unsigned A < B. All other edges hold the flags.

Reset
REQ-023 SHALL: with reset=0 at a rising edge, all 16 registers and psr_flags become 0, overriding reg_write.
REQ-024 SHALL: deasserting reset mid-sequence causes no spurious write on the first edge with reset=1 unless reg_write=1.

Structure
REQ-025 SHALL: shared package holds the alu_cont opcode constants, the reg_write_src encodings and the flag bit indices.
REQ-026 SHALL: the ALU is one sub-module, alu (A, B, alu_cont -> result, flag vector); the register file, muxes and flag register are inline.

Verification
REQ-027 SHALL: load immediate: inst 16'h0103, alu_A_src=0, alu_B_src=1, alu_cont=111111, reg_write=1, reg_write_src=0 -> R1=3; then inst 16'h0202 -> R2=2.
REQ-028 SHALL: add: inst 16'h0102, alu_A_src=1, alu_B_src=0, alu_cont=000101, reg_write=1 -> R1=5; C=0, Z=0.
REQ-029 SHALL: store path: inst 16'h0104, alu_A_src=1, alu_B_src=1 -> mem_address_load_stor=4, data_to_mem_stor=5; a memory model with we=1 stores 5 at address 4.
REQ-030 SHALL: load write-back: memory returns 5 the cycle after address 4, inst 16'h0300, reg_write_src=1, reg_write=1 -> R3=5; A_index=3, op_code=0.
REQ-031 SHALL: boundaries: ADD 16'hFFFF + 1 -> result 0, C=1, Z=1; imm8=8'h80 with PASS -> 16'hFF80; CMP 16'h8000 vs 1 -> N=1, L=0.
REQ-032 SHALL: reset: reset=0 with reg_write=1 for one edge -> all registers and psr_flags read 0.
